// File: rtl/clock_set_ctrl.sv
// Settable HH:MM:SS clock with three debounced active-low buttons.
// Mode toggles CLOCK/SET; in SET, pos selects a field and inc bumps it without carry.
module clock_set_ctrl #(
  parameter logic [31:0] P_TICK_NUM = 32'd50000000,
  parameter logic [31:0] P_DEB_NUM  = 32'd500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic [5:0] o_six_dp
);

  typedef enum logic {
    ST_CLOCK = 1'b0,
    ST_SET   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;

  // Button vector order: {inc, pos, mode}
  logic [2:0] sw_raw;
  logic [2:0] sync_q1;
  logic [2:0] sync_q2;
  logic [2:0] samp_q;
  logic [2:0] pressed_q;
  logic [2:0] pulse_q;
  logic [2:0] press_det;
  logic [2:0] rel_det;

  logic [31:0] deb_cnt;
  logic        deb_stb;

  logic [31:0] tick_cnt;
  logic        tick;

  state_t state_q;
  state_t state_d;
  pos_t   pos_q;
  pos_t   pos_d;

  logic [5:0] sec_q;
  logic [5:0] sec_d;
  logic [5:0] min_q;
  logic [5:0] min_d;
  logic [4:0] hour_q;
  logic [4:0] hour_d;

  logic mode_p;
  logic pos_p;
  logic inc_p;
  logic inc_en;

  assign sw_raw = {i_sw_inc, i_sw_pos, i_sw_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign deb_stb = (deb_cnt == P_DEB_NUM - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
    end else if (deb_stb) begin
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 32'd1;
    end
  end

  // samp_q holds the previous strobed sample; two equal samples in a row move the state.
  assign press_det = ~pressed_q & ~sync_q2 & ~samp_q;
  assign rel_det   =  pressed_q &  sync_q2 &  samp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q    <= '1;
      pressed_q <= '0;
      pulse_q   <= '0;
    end else if (deb_stb) begin
      samp_q    <= sync_q2;
      pressed_q <= (pressed_q | press_det) & ~rel_det;
      pulse_q   <= press_det;
    end else begin
      pulse_q   <= '0;
    end
  end

  assign mode_p = pulse_q[0];
  assign pos_p  = pulse_q[1];
  assign inc_p  = pulse_q[2];

  assign tick = (state_q == ST_CLOCK) && (tick_cnt == P_TICK_NUM - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if ((state_q == ST_SET) || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLOCK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      state_d = (state_q == ST_CLOCK) ? ST_SET : ST_CLOCK;
    end
  end

  always_comb begin
    o_mode   = (state_q == ST_SET);
    o_six_dp = '0;
    if (state_q == ST_SET) begin
      case (pos_q)
        POS_SEC:  o_six_dp = 6'b000011;
        POS_MIN:  o_six_dp = 6'b001100;
        POS_HOUR: o_six_dp = 6'b110000;
        default:  o_six_dp = '0;
      endcase
    end
  end

  always_comb begin
    pos_d = pos_q;
    if ((state_q == ST_SET) && pos_p) begin
      case (pos_q)
        POS_SEC:  pos_d = POS_MIN;
        POS_MIN:  pos_d = POS_HOUR;
        default:  pos_d = POS_SEC;
      endcase
    end
    if ((state_q == ST_CLOCK) && (state_d == ST_SET)) begin
      pos_d = POS_SEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= POS_SEC;
    end else begin
      pos_q <= pos_d;
    end
  end

  // A coincident mode pulse discards the increment.
  assign inc_en = (state_q == ST_SET) && inc_p && !mode_p;

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    if (inc_en) begin
      case (pos_q)
        POS_SEC:  sec_d  = (sec_q  == 6'd59) ? '0 : sec_q  + 6'd1;
        POS_MIN:  min_d  = (min_q  == 6'd59) ? '0 : min_q  + 6'd1;
        POS_HOUR: hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
        default:  sec_d  = sec_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
  assign o_position = pos_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with a time-of-day model driven by sampled button history.
module tb_clock_set_ctrl;

  localparam int TICK = 4;
  localparam int DEB  = 2;
  localparam int HMAX = 16384;
  localparam logic [2:0] B_MODE = 3'b001;
  localparam logic [2:0] B_POS  = 3'b010;
  localparam logic [2:0] B_INC  = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] sw = 3'b111;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_mode;
  logic [1:0] o_position;
  logic [5:0] o_six_dp;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  clock_set_ctrl #(
    .P_TICK_NUM(32'd4),
    .P_DEB_NUM (32'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sw_mode (sw[0]),
    .i_sw_pos  (sw[1]),
    .i_sw_inc  (sw[2]),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_hour    (o_hour),
    .o_mode    (o_mode),
    .o_position(o_position),
    .o_six_dp  (o_six_dp)
  );

  always #5 clk = ~clk;

  // Model state: time as plain integers, buttons as a history of sampled levels.
  bit [2:0] raw_hist [0:HMAX-1];
  int k      = 0;
  int m_sec  = 0;
  int m_min  = 0;
  int m_hour = 0;
  int m_pos  = 0;
  bit m_mode = 1'b0;
  int m_tcnt = 0;
  bit [2:0] m_pressed = '0;
  bit [2:0] m_pend = '0;

  function automatic bit [2:0] raw_at(input int j);
    if (j < 1) return 3'b111;
    return raw_hist[j];
  endfunction

  task automatic model_step();
    bit mp, pp, ip, s_now, s_prev;
    bit [2:0] a, b, nxt;
    int t;
    if (!rst_n) begin
      k = 0; m_sec = 0; m_min = 0; m_hour = 0; m_pos = 0;
      m_mode = 1'b0; m_tcnt = 0; m_pressed = '0; m_pend = '0;
      return;
    end
    k++;
    if (k >= HMAX) begin
      $display("FAIL model_hist: history depth %0d exceeded, limit %0d", k, HMAX);
      $fatal(1);
    end
    raw_hist[k] = sw;
    mp = m_pend[0]; pp = m_pend[1]; ip = m_pend[2];
    if (!m_mode) begin
      if (m_tcnt == TICK - 1) begin
        m_tcnt = 0;
        t = (m_hour * 3600 + m_min * 60 + m_sec + 1) % 86400;
        m_hour = t / 3600;
        m_min  = (t / 60) % 60;
        m_sec  = t % 60;
      end else begin
        m_tcnt++;
      end
    end else begin
      m_tcnt = 0;
      if (ip && !mp) begin
        case (m_pos)
          0:       m_sec  = (m_sec + 1) % 60;
          1:       m_min  = (m_min + 1) % 60;
          default: m_hour = (m_hour + 1) % 24;
        endcase
      end
      if (pp) m_pos = (m_pos + 1) % 3;
    end
    if (mp) begin
      m_mode = !m_mode;
      if (m_mode) m_pos = 0;
    end
    // Strobed samples every DEB cycles, seen two cycles after the pin.
    nxt = '0;
    if (k % DEB == 0) begin
      a = raw_at(k - 2);
      b = raw_at(k - 2 - DEB);
      for (int i = 0; i < 3; i++) begin
        s_now = a[i]; s_prev = b[i];
        if (!m_pressed[i] && !s_now && !s_prev) begin
          m_pressed[i] = 1'b1;
          nxt[i] = 1'b1;
        end else if (m_pressed[i] && s_now && s_prev) begin
          m_pressed[i] = 1'b0;
        end
      end
    end
    m_pend = nxt;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    logic [5:0] exp_dp;
    @(negedge clk);
    if (cmp_on) begin
      exp_dp = m_mode ? (6'b000011 << (2 * m_pos)) : 6'b000000;
      n_checks++;
      if (o_sec == 6'(m_sec) && o_min == 6'(m_min) && o_hour == 5'(m_hour) &&
          o_mode == m_mode && o_position == 2'(m_pos) && o_six_dp == exp_dp) begin
        n_pass++;
      end else begin
        $display("FAIL model_cmp t=%0t: got %0d:%0d:%0d mode%0d pos%0d dp%b, want %0d:%0d:%0d mode%0d pos%0d dp%b",
                 $time, o_hour, o_min, o_sec, o_mode, o_position, o_six_dp,
                 m_hour, m_min, m_sec, m_mode, m_pos, exp_dp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({o_hour, o_min, o_sec, o_mode, o_position, o_six_dp}), 0);
  endtask

  task automatic press(input logic [2:0] which, input int hold);
    @(negedge clk);
    sw = ~which;
    repeat (hold) @(negedge clk);
    sw = 3'b111;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_n(input logic [2:0] which, input int n);
    for (int i = 0; i < n; i++) press(which, 8);
  endtask

  task automatic wait_mode(input logic want);
    int n = 0;
    while (o_mode != want && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mode_wait", int'(o_mode), int'(want));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    cmp_on = 1'b1;
    rst_n = 1'b1;

    // Free-running count from reset release.
    repeat (4) @(posedge clk);
    #1 chk("sec_after_4", int'(o_sec), 1);
    repeat (236) @(posedge clk);
    #1 chk("min_after_240", int'(o_min), 1);
    chk("sec_after_240", int'(o_sec), 0);

    // Mode held through reset; one tick lands before the press qualifies.
    @(negedge clk);
    rst_n = 1'b0;
    sw = ~B_MODE;
    #1 chk_all_zero("reset_midrun");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    sw = 3'b111;
    repeat (10) @(negedge clk);
    chk("held_mode_set", int'(o_mode), 1);
    chk("sec_at_set", int'(o_sec), 1);

    press_n(B_INC, 3);
    chk("inc3_sec", int'(o_sec), 4);
    chk("inc3_min", int'(o_min), 0);
    chk("inc3_dp", int'(o_six_dp), 6'b000011);
    press(B_POS, 8);
    chk("pos_min", int'(o_position), 1);
    chk("pos_min_dp", int'(o_six_dp), 6'b001100);

    press(B_POS, 8);
    chk("pos_hour", int'(o_position), 2);
    chk("pos_hour_dp", int'(o_six_dp), 6'b110000);
    press_n(B_INC, 23);
    chk("hour_23", int'(o_hour), 23);
    press(B_INC, 8);
    chk("hour_wrap", int'(o_hour), 0);
    chk("hour_wrap_min", int'(o_min), 0);
    press(B_INC, 20);
    chk("hold_one_inc", int'(o_hour), 1);

    press_n(B_INC, 21);
    press(B_POS | B_INC, 8);
    chk("pos_inc_hour", int'(o_hour), 23);
    chk("pos_inc_pos", int'(o_position), 0);
    press_n(B_INC, 55);
    press(B_POS, 8);
    press_n(B_INC, 59);
    chk("pre_sec", int'(o_sec), 59);
    chk("pre_min", int'(o_min), 59);
    chk("pre_hour", int'(o_hour), 23);

    // Back to CLOCK: first tick a full four cycles after the mode change.
    @(negedge clk);
    sw = ~B_MODE;
    wait_mode(1'b0);
    repeat (3) @(posedge clk);
    #1 chk("pre_tick_sec", int'(o_sec), 59);
    @(posedge clk);
    #1 chk("rollover_h", int'(o_hour), 0);
    chk("rollover_m", int'(o_min), 0);
    chk("rollover_s", int'(o_sec), 0);

    // Release now, re-press so the mode pulse lands on the fourth tick.
    @(negedge clk);
    sw = 3'b111;
    repeat (5) @(posedge clk);
    @(negedge clk);
    sw = ~B_MODE;
    repeat (6) @(posedge clk);
    #1 chk("coin_before_mode", int'(o_mode), 0);
    chk("coin_before_sec", int'(o_sec), 2);
    @(posedge clk);
    #1 chk("coin_mode", int'(o_mode), 1);
    chk("coin_sec", int'(o_sec), 3);
    @(negedge clk);
    sw = 3'b111;
    repeat (10) @(negedge clk);

    @(negedge clk);
    sw = ~(B_MODE | B_INC);
    wait_mode(1'b0);
    chk("mode_inc_sec", int'(o_sec), 3);
    chk("mode_inc_min", int'(o_min), 0);
    repeat (8) @(negedge clk);
    sw = 3'b111;
    repeat (10) @(negedge clk);

    press(B_MODE, 8);
    press(B_POS, 8);
    press_n(B_INC, 5);
    chk("set_min5", int'(o_min), 5);
    chk("set_min5_mode", int'(o_mode), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("sec_after_rst", int'(o_sec), 1);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
